// File: rtl/data_memory_be.sv
// data_memory_be: byte-addressed, byte-enabled data memory for the MIPS datapath.
// Supports sb/sh/sw stores and lb/lbu/lh/lhu/lw loads with a 1-cycle registered
// read port. After reset a sequencer zeroes the array, and `ready` rises when it finishes.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned half/word
// accesses are suppressed and flagged on `misalign`.
module data_memory_be #(
  parameter int DEPTH_WORDS    = 256,
  parameter int ADDR_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic              misalign
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]      read_data_q, read_data_d;
  logic             ready_q, ready_d;
  logic             misalign_q, misalign_d;

  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] acc_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic [7:0]       rd_lane [4];
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             misaligned_acc;
  logic             store_en;
  logic             load_en;
  logic             unused_addr_hi;

  // Word index wraps modulo DEPTH_WORDS; upper address bits simply alias.
  assign acc_idx        = addr[IDX_W+1:2];
  assign unused_addr_hi = |addr[ADDR_W-1:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
  // Half needs addr[0]=0 and word (size 10/11) needs addr[1:0]=0. Bytes are always aligned.
  assign misaligned_acc = ((size == 2'b01) && addr[0]) ||
                          (size[1] && (addr[1:0] != 2'b00));
`else
  assign misaligned_acc = 1'b0;
`endif

  assign store_en = ready_q & mem_write & ~misaligned_acc;
  assign load_en  = ready_q & mem_read  & ~misaligned_acc;

  // Split the addressed word into little-endian byte lanes.
  assign rd_word = mem[acc_idx];
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_lane
      assign rd_lane[gi] = rd_word[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_lane[addr[1:0]];
  assign half_sel = addr[1] ? rd_word[31:16] : rd_word[15:0];

  // Write port: the clear sequencer owns the array while clearing; otherwise stores use lane enables.
  always_comb begin
    wr_idx  = acc_idx;
    wr_be   = 4'b0000;
    wr_data = write_data;
    if (state_q == ST_CLEAR) begin
      wr_idx  = clr_cnt_q;
      wr_be   = 4'hF;
      wr_data = '0;
    end else if (store_en) begin
      case (size)
        2'b00: begin
          wr_be   = 4'b0001 << addr[1:0];
          wr_data = {4{write_data[7:0]}};
        end
        2'b01: begin
          wr_be   = addr[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{write_data[15:0]}};
        end
        default: begin
          wr_be   = 4'hF;
          wr_data = write_data;
        end
      endcase
    end
  end

  // Byte-enabled array write. Contents are never reset directly.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) begin
          mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Load result: extend the selected byte or half. Hold the previous value when there is no load.
  always_comb begin
    read_data_d = read_data_q;
    if (load_en) begin
      case (size)
        2'b00:   read_data_d = {{24{~unsigned_ld & byte_sel[7]}}, byte_sel};
        2'b01:   read_data_d = {{16{~unsigned_ld & half_sel[15]}}, half_sel};
        default: read_data_d = rd_word;
      endcase
    end
  end

  // Clear sequencer next state, plus ready and misalign flags.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + IDX_W'(1);
      if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) begin
        state_d = ST_READY;
      end
    end
    ready_d    = (state_d == ST_READY);
    misalign_d = ready_q & (mem_read | mem_write) & misaligned_acc;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_cnt_q   <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      misalign_q  <= misalign_d;
    end
  end

  assign read_data = read_data_q;
  assign ready     = ready_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: directed-vector bench for data_memory_be (DEPTH_WORDS=256).
// Expectations follow DMEM_ALIGN_CHECK_EN when the macro is defined.
module tb_data_memory_be;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [1:0]  size = 2'b10;
  logic        unsigned_ld = 1'b0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  data_memory_be #(
    .DEPTH_WORDS    (256),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .addr        (addr),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .write_data  (write_data),
    .read_data   (read_data),
    .ready       (ready),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // One access cycle: drive on the falling edge, commit at the rising edge, sample 1 time unit later.
  task automatic access(input logic we, input logic re, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_write   = we;
    mem_read    = re;
    size        = sz;
    unsigned_ld = uns;
    addr        = a;
    write_data  = wd;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
  endtask

  // Single-edge reset pulse; returns 1 time unit after the reset edge.
  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Count edges after the reset edge until ready rises, with a bounded wait.
  task automatic wait_ready(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_v;

    // Reset state and clear duration. Accesses held during clearing must be ignored.
    @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    rst         = 1'b0;
    mem_write   = 1'b1;
    mem_read    = 1'b1;
    size        = 2'b10;
    addr        = 32'h40;
    write_data  = 32'hFFFF_FFFF;
    wait_ready("clear_cycles", 256);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    chk("clear_rdata_held0", read_data, 32'h0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
    chk("lw_0x40_cleared", read_data, 32'h0);

    // Byte/half loads from a full word.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h1122_3344);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h0);
    chk("lb_0x21", read_data, 32'h0000_0033);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h23, 32'h0);
    chk("lbu_0x23", read_data, 32'h0000_0011);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0);
    chk("lh_0x22", read_data, 32'h0000_1122);

    // Partial stores with extension.
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0000_0080);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("sb_lw_0x20", read_data, 32'h1180_3344);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'h0);
    chk("lb_0x22", read_data, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h22, 32'h0);
    chk("lbu_0x22", read_data, 32'h0000_0080);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0000_BEEF);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h0);
    chk("lh_0x20", read_data, 32'hFFFF_BEEF);
    access(1'b0, 1'b1, 2'b01, 1'b1, 32'h20, 32'h0);
    chk("lhu_0x20", read_data, 32'h0000_BEEF);
    access(1'b0, 1'b1, 2'b11, 1'b1, 32'h20, 32'h0);
    chk("size11_word", read_data, 32'h1180_BEEF);

    // Read-first on a simultaneous access, then address wrap.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'hAAAA_AAAA);
    access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h5555_5555);
    chk("read_first", read_data, 32'hAAAA_AAAA);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("after_rw", read_data, 32'h5555_5555);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h1234_5678);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("wrap_0x400", read_data, 32'h1234_5678);
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0BAD_F00D);
    chk("hold_no_read", read_data, 32'h1234_5678);

    // Misaligned word store to 0x42.
    access(1'b1, 1'b0, 2'b10, 1'b0, 32'h42, 32'hDEAD_BEEF);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("misalign_pulse", {31'b0, misalign}, 32'h1);
`else
    chk("misalign_pulse", {31'b0, misalign}, 32'h0);
`endif
    access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("misalign_clear", {31'b0, misalign}, 32'h0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    exp_v = 32'h0;
`else
    exp_v = 32'hDEAD_BEEF;
`endif
    chk("lw_0x40_after_mis", read_data, exp_v);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h0);
    chk("lw_0x41_mis", read_data, exp_v);

    // Reset from READY, then a second reset about 100 cycles into the clear.
    pulse_rst();
    chk("rst2_ready", {31'b0, ready}, 32'h0);
    chk("rst2_rdata", read_data, 32'h0);
    repeat (100) @(posedge clk);
    #1;
    chk("midclear_not_ready", {31'b0, ready}, 32'h0);
    pulse_rst();
    wait_ready("midclear_cycles", 256);
    access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("lw_0x20_recleared", read_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_be.md
Name: data_memory_be

Overview:
Byte-addressed, byte-enabled data memory for the single-cycle MIPS datapath. It is the parametrised successor of the word-indexed data memory. It supports sb/sh/sw stores and lb/lbu/lh/lhu/lw loads with sign/zero extension, and has a registered read port with 1-cycle latency. A reset-triggered clear sequencer zeroes the array and signals readiness through a ready flag.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; must be a power of two.
ADDR_W, 32, width of the byte address input.
CLEAR_ON_RESET, 1, 1 = sequentially zero all words after reset; 0 = skip clearing.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
addr  input  ADDR_W  byte address
mem_write  input  1  store enable
mem_read  input  1  load enable
size  input  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
unsigned_ld  input  1  1 = zero-extend a byte/half load; 0 = sign-extend
write_data  input  32  store data; the low byte/half is used for sb/sh
read_data  output  32  registered, extended load result
ready  output  1  1 = memory accepts accesses
misalign  output  1  1-cycle error pulse (see Optional Feature)

Behaviour:
- Reset is synchronous: rst sampled high at a clk edge sets state=CLEAR (or READY if CLEAR_ON_RESET=0), clr_cnt=0, read_data=0, ready=0, misalign=0.
- Array contents are not reset directly. They are cleared only by the sequencer.
- States:
  - CLEAR: each cycle writes 0 to word[clr_cnt], then clr_cnt++. After writing word DEPTH_WORDS-1, go to READY.
  - READY: ready=1 from the first cycle in READY.
  - With CLEAR_ON_RESET=1, ready goes high exactly DEPTH_WORDS cycles after the edge at which rst is last sampled high.
  - With CLEAR_ON_RESET=0, ready goes high 1 cycle after that edge.
- rst asserted mid-CLEAR restarts clr_cnt at 0. rst in READY returns to CLEAR.
- While ready=0, mem_read/mem_write are ignored and read_data holds 0.
- Word index = addr[ADDR_W-1:2] modulo DEPTH_WORDS. Higher addresses wrap and alias; no error is raised.
- Little-endian lanes: byte lane k = bits [8k+7:8k], selected by addr[1:0].
- Stores, committed at the clk edge:
  - Byte: write_data[7:0] goes to lane addr[1:0]; other lanes are unchanged.
  - Half: write_data[15:0] goes to lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes are written.
- Loads, 1-cycle latency: read_data is updated at the edge where mem_read=1. The value is available the following cycle and holds until the next load or reset.
  - Byte: lane addr[1:0], extended per unsigned_ld.
  - Half: lanes selected by addr[1], extended per unsigned_ld.
  - Word: the full word; unsigned_ld is ignored.
- Simultaneous read and write to the same word is read-first: read_data returns the pre-write contents.
- mem_read=0 leaves read_data unchanged.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, is misaligned.
  - The store is suppressed.
  - read_data is unchanged.
  - misalign is 1 for exactly the cycle after the offending edge.
  - Byte accesses are never misaligned.
  - misalign is 0 during CLEAR.
- Undefined: misalign is tied to 0. For half accesses addr[0] is ignored; for word accesses addr[1:0] are ignored.

Test Plan:
- Reset/clear: rst high for 1 edge with DEPTH_WORDS=256 → ready=0 for 256 cycles, then 1. lw 0x40 → 0x00000000. Pre-clear stores are ignored.
- Byte loads: sw 0x11223344 @0x20, then:
  - lb @0x21 → 0x00000033
  - lbu @0x23 → 0x00000011
  - lh @0x22 → 0x00001122
- Partial stores with extension:
  - sb 0x80 @0x22, then lw @0x20 → 0x11803344; lb @0x22 → 0xFFFFFF80; lbu @0x22 → 0x00000080.
  - sh 0xBEEF @0x20, then lh → 0xFFFFBEEF; lhu → 0x0000BEEF.
- Read-first and wrap:
  - sw 0xAAAAAAAA @0x0, then same-cycle lw+sw 0x55555555 @0x0 → read_data=0xAAAAAAAA; the next lw → 0x55555555.
  - sw 0x12345678 @0x400 → lw @0x0 returns 0x12345678.
- Reset mid-clear: rst at clear cycle 100 → ready rises 256 cycles after the second reset edge, not earlier.
- Misalign with DMEM_ALIGN_CHECK_EN:
  - sw 0xDEADBEEF @0x42 → misalign=1 for one cycle; the word at 0x40 is unchanged.
  - Same stimulus without the macro → word 0x40 = 0xDEADBEEF, misalign=0.
